ifu_fq: RTL

Parametrised fetch unit: generates fetch PCs from branch-predictor output and issues them to an instruction memory with variable latency and multiple outstanding requests. Responses land in a FQ_DEPTH-entry fetch queue drained by decode over a valid/ready handshake. Handles ctrl flush and exu mispredict redirects by killing in-flight requests and clearing the queue. Sits between bp, instruction memory and decode; replaces a single-cycle-ROM fetch stage.

---
 rtl/ifu_fq.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ifu_fq.sv
// Fetch unit with multi-outstanding instruction memory requests.
// Responses are queued for decode; redirects kill in-flight fetches.
module ifu_fq #(
   parameter int ADDR_W = 32,
   parameter int INST_W = 32,
   parameter int FQ_DEPTH = 4,
   parameter int MAX_OUT = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic [ADDR_W-1:0] new_pc_i,
   input  logic              branch_redirect_i,
   input  logic [ADDR_W-1:0] branch_redirect_pc_i,
   output logic [ADDR_W-1:0] bp_pc_o,
   input  logic [ADDR_W-1:0] bp_next_pc_i,
   input  logic              bp_taken_i,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [INST_W-1:0] mem_rdata_i,
   output logic              id_valid_o,
   input  logic              id_ready_i,
   output logic [ADDR_W-1:0] id_pc_o,
   output logic [INST_W-1:0] id_inst_o,
   output logic [ADDR_W-1:0] id_next_pc_o,
   output logic              id_taken_o,
   output logic              id_branch_slot_end_o,
   output logic              stall_req_o
);

   localparam int FA_W = $clog2(FQ_DEPTH);
   localparam int FC_W = FA_W + 1;
   localparam int PA_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int PC_W = $clog2(MAX_OUT) + 1;
   localparam logic [FC_W-1:0] FQ_N = FC_W'(FQ_DEPTH);
   localparam logic [PC_W-1:0] PD_N = PC_W'(MAX_OUT);
   localparam logic [PA_W-1:0] PD_LAST = PA_W'(MAX_OUT - 1);

   logic [ADDR_W-1:0] fpc;
   logic              sep;

   logic [ADDR_W-1:0] pd_pc  [MAX_OUT];
   logic [ADDR_W-1:0] pd_npc [MAX_OUT];
   logic [MAX_OUT-1:0] pd_tk;
   logic [MAX_OUT-1:0] pd_se;
   logic [MAX_OUT-1:0] pd_kill;
   logic [PA_W-1:0]   pd_wp;
   logic [PA_W-1:0]   pd_rp;
   logic [PC_W-1:0]   pd_cnt;

   logic [ADDR_W-1:0] fq_pc   [FQ_DEPTH];
   logic [INST_W-1:0] fq_inst [FQ_DEPTH];
   logic [ADDR_W-1:0] fq_npc  [FQ_DEPTH];
   logic [FQ_DEPTH-1:0] fq_tk;
   logic [FQ_DEPTH-1:0] fq_se;
   logic [FA_W-1:0]   fq_wp;
   logic [FA_W-1:0]   fq_rp;
   logic [FC_W-1:0]   fq_cnt;

   logic [FC_W-1:0] occ;
   logic redir;
   logic grant;
   logic rsp;
   logic fq_push;
   logic fq_pop;
   logic fq_vld;

   function automatic logic [PA_W-1:0] pd_inc(input logic [PA_W-1:0] p);
      return (p == PD_LAST) ? '0 : p + 1'b1;
   endfunction

   assign redir   = flush_i | branch_redirect_i;
   assign occ     = fq_cnt + FC_W'(pd_cnt);
   assign mem_req_o = (occ < FQ_N) & (pd_cnt < PD_N) & ~redir & ~rst_i;
   assign mem_addr_o = fpc;
   assign bp_pc_o = fpc;
   assign grant   = mem_req_o & mem_gnt_i;
   assign rsp     = mem_rvalid_i & (pd_cnt != '0);
   assign fq_push = rsp & ~pd_kill[pd_rp] & ~redir;
   assign fq_vld  = (fq_cnt != '0) & ~rst_i;
   assign fq_pop  = fq_vld & id_ready_i & ~redir;

   assign id_valid_o = fq_vld;
   assign id_pc_o = fq_vld ? fq_pc[fq_rp] : '0;
   assign id_inst_o = fq_vld ? fq_inst[fq_rp] : '0;
   assign id_next_pc_o = fq_vld ? fq_npc[fq_rp] : '0;
   assign id_taken_o = fq_vld & fq_tk[fq_rp];
   assign id_branch_slot_end_o = fq_vld & fq_se[fq_rp];
   assign stall_req_o = ~fq_vld;

   // fetch PC and redirect-slot marker
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fpc <= RESET_PC;
         sep <= 1'b0;
      end else if (flush_i) begin
         fpc <= new_pc_i;
         sep <= 1'b0;
      end else if (branch_redirect_i) begin
         fpc <= branch_redirect_pc_i;
         sep <= 1'b1;
      end else if (grant) begin
         fpc <= bp_next_pc_i;
         sep <= 1'b0;
      end
   end

   // in-flight request tracking; redirect marks all as killed
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pd_wp <= '0;
         pd_rp <= '0;
         pd_cnt <= '0;
         pd_kill <= '0;
      end else begin
         if (redir) pd_kill <= '1;
         if (grant) begin
            pd_pc[pd_wp] <= fpc;
            pd_npc[pd_wp] <= bp_next_pc_i;
            pd_tk[pd_wp] <= bp_taken_i;
            pd_se[pd_wp] <= sep;
            pd_kill[pd_wp] <= 1'b0;
            pd_wp <= pd_inc(pd_wp);
         end
         if (rsp) pd_rp <= pd_inc(pd_rp);
         pd_cnt <= pd_cnt + PC_W'(grant) - PC_W'(rsp);
      end
   end

   // fetch queue toward decode; cleared on redirect
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fq_wp <= '0;
         fq_rp <= '0;
         fq_cnt <= '0;
      end else if (redir) begin
         fq_wp <= '0;
         fq_rp <= '0;
         fq_cnt <= '0;
      end else begin
         if (fq_push) begin
            fq_pc[fq_wp] <= pd_pc[pd_rp];
            fq_inst[fq_wp] <= mem_rdata_i;
            fq_npc[fq_wp] <= pd_npc[pd_rp];
            fq_tk[fq_wp] <= pd_tk[pd_rp];
            fq_se[fq_wp] <= pd_se[pd_rp];
            fq_wp <= fq_wp + 1'b1;
         end
         if (fq_pop) fq_rp <= fq_rp + 1'b1;
         fq_cnt <= fq_cnt + FC_W'(fq_push) - FC_W'(fq_pop);
      end
   end

endmodule
